host_cpu_oci_dct_ctrl: RTL and testbench

Packs 2-bit trace atoms from the host CPU debug core into the 30-bit `dct_buffer` and 4-bit `dct_count` pair that feeds the OCI trace test bench. Completed or flushed buffers are moved into a single-entry frame register and handed to trace memory over a valid/ready handshake. The block also sequences end-of-test: `test_ending` forces a final flush, and `test_has_ended` asserts once the last frame has drained.

---
 rtl/host_cpu_oci_dct_ctrl_if.sv | 31 +++
 rtl/host_cpu_oci_dct_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_host_cpu_oci_dct_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/host_cpu_oci_dct_ctrl_if.sv
// Atom ingress and frame egress signals of the OCI trace packer.
// The master modport is the atom producer and frame consumer; the slave modport is the packer.
interface host_cpu_oci_dct_ctrl_if #(
    parameter int ATOM_W = 2,
    parameter int SLOTS  = 15
);
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int FRM_W = CNT_W + ATOM_W * SLOTS;

    logic              atom_valid;
    logic [ATOM_W-1:0] atom;
    logic              frm_valid;
    logic [FRM_W-1:0]  frm_data;
    logic              frm_ready;

    modport master (
        output atom_valid,
        output atom,
        output frm_ready,
        input  frm_valid,
        input  frm_data
    );

    modport slave (
        input  atom_valid,
        input  atom,
        input  frm_ready,
        output frm_valid,
        output frm_data
    );
endinterface

// File: rtl/host_cpu_oci_dct_ctrl.sv
// Packs host CPU trace atoms into dct_buffer/dct_count, emits frames and sequences end-of-test.
// Optional feature macro: DCT_DROP_COUNT_EN (saturating 8-bit overflow drop counter).
module host_cpu_oci_dct_ctrl #(
    parameter int ATOM_W = 2,
    parameter int SLOTS  = 15,
    localparam int CNT_W = $clog2(SLOTS + 1),
    localparam int BUF_W = ATOM_W * SLOTS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    host_cpu_oci_dct_ctrl_if.slave        bus,
    input  logic                          flush_req,
    input  logic                          test_ending,
    output logic [BUF_W-1:0]              dct_buffer,
    output logic [CNT_W-1:0]              dct_count,
    output logic                          atom_drop,
    output logic [7:0]                    drop_cnt,
    output logic                          test_has_ended
);
    localparam int FRM_W = CNT_W + BUF_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOTS);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENDED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fv_q, fv_d;
    logic [FRM_W-1:0]   fdata_q, fdata_d;
    logic               flush_pend_q, flush_pend_d;
    logic               end_pend_q, end_pend_d;
    logic               drop_q, drop_d;
    logic               ended_q, ended_d;

    logic               hold_free_s;
    logic               cnt_full_s;
    logic               xfer_s;
    logic               run_s;
    logic               accept_s;
    logic [CNT_W-1:0]   base_cnt_s;

    // Transfer/accept/drop decisions from the current registered state.
    always_comb begin
        hold_free_s = !fv_q | bus.frm_ready;
        cnt_full_s  = (cnt_q == CNT_MAX);
        xfer_s      = hold_free_s & (cnt_full_s | (flush_pend_q & (cnt_q != CNT_ZERO)));
        run_s       = (state_q == ST_RUN);
        accept_s    = bus.atom_valid & run_s & (!cnt_full_s | xfer_s);
        drop_d      = bus.atom_valid & run_s & cnt_full_s & !xfer_s;
    end

    // Packing buffer: a transfer empties it, so a same-cycle atom lands in slot 0.
    always_comb begin
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        base_cnt_s = cnt_q;
        if (xfer_s) begin
            buf_d      = {BUF_W{1'b0}};
            base_cnt_s = CNT_ZERO;
        end else begin
            buf_d      = buf_q;
            base_cnt_s = cnt_q;
        end
        if (accept_s) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (base_cnt_s == CNT_W'(s)) begin
                    buf_d[s*ATOM_W +: ATOM_W] = bus.atom;
                end else begin
                    buf_d[s*ATOM_W +: ATOM_W] = buf_d[s*ATOM_W +: ATOM_W];
                end
            end
            cnt_d = base_cnt_s + CNT_W'(1);
        end else begin
            cnt_d = base_cnt_s;
        end
    end

    // Single-entry frame register and the pending-flush flag.
    always_comb begin
        fv_d         = fv_q;
        fdata_d      = fdata_q;
        flush_pend_d = flush_pend_q;
        if (xfer_s) begin
            fv_d    = 1'b1;
            fdata_d = {cnt_q, buf_q};
        end else if (bus.frm_ready) begin
            fv_d    = 1'b0;
        end else begin
            fv_d    = fv_q;
        end
        // A flush against an empty buffer simply evaporates.
        if (xfer_s | (cnt_q == CNT_ZERO)) begin
            flush_pend_d = 1'b0;
        end else begin
            flush_pend_d = flush_pend_q;
        end
        if (flush_req | (run_s & test_ending)) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_d;
        end
    end

    // End-of-test sequencer next state.
    always_comb begin
        state_d    = state_q;
        end_pend_d = end_pend_q;
        ended_d    = ended_q;
        case (state_q)
            ST_RUN: begin
                if (test_ending | end_pend_q) begin
                    state_d    = ST_DRAIN;
                    end_pend_d = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((cnt_q == CNT_ZERO) & !fv_q) begin
                    state_d = ST_ENDED;
                    ended_d = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_ENDED: begin
                state_d = ST_ENDED;
                ended_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            buf_q        <= {BUF_W{1'b0}};
            cnt_q        <= CNT_ZERO;
            fv_q         <= 1'b0;
            fdata_q      <= {FRM_W{1'b0}};
            flush_pend_q <= 1'b0;
            end_pend_q   <= 1'b0;
            drop_q       <= 1'b0;
            ended_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            fv_q         <= fv_d;
            fdata_q      <= fdata_d;
            flush_pend_q <= flush_pend_d;
            end_pend_q   <= end_pend_d;
            drop_q       <= drop_d;
            ended_q      <= ended_d;
        end
    end

`ifdef DCT_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of overflow drops.
    always_comb begin
        if (drop_q && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign bus.frm_valid  = fv_q;
    assign bus.frm_data   = fdata_q;
    assign atom_drop      = drop_q;
    assign test_has_ended = ended_q;
endmodule

// File: tb/tb_host_cpu_oci_dct_ctrl.sv
// Randomized and directed bench for host_cpu_oci_dct_ctrl against a queue-based reference model.
module tb_host_cpu_oci_dct_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush_req = 1'b0;
    logic        test_ending = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        atom_drop;
    logic [7:0]  drop_cnt;
    logic        test_has_ended;

    int checks = 0;
    int errors = 0;
    int seen_drops = 0;

    host_cpu_oci_dct_ctrl_if bus ();

    host_cpu_oci_dct_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .atom_drop      (atom_drop),
        .drop_cnt       (drop_cnt),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    // Reference model: buffer is a queue of atoms, phase 0=run 1=drain 2=ended.
    logic [1:0]  m_q[$];
    bit          m_fv = 1'b0;
    logic [33:0] m_fd = 34'd0;
    bit          m_flush = 1'b0;
    int          m_phase = 0;
    bit          m_drop = 1'b0;
    int          m_dcnt = 0;
    bit          m_ended = 1'b0;

    function automatic logic [29:0] pack(input logic [1:0] q[$]);
        logic [29:0] r;
        r = 30'd0;
        foreach (q[i]) r[2*i +: 2] = q[i];
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int n;
        bit fv0, fl0, drop0, send;
        int ph0;
        if (!reset_n) begin
            m_q.delete();
            m_fv = 1'b0; m_fd = 34'd0; m_flush = 1'b0; m_phase = 0;
            m_drop = 1'b0; m_dcnt = 0; m_ended = 1'b0;
        end else begin
            n = m_q.size(); fv0 = m_fv; fl0 = m_flush; ph0 = m_phase; drop0 = m_drop;
            send = (!fv0 || bus.frm_ready) && (n == 15 || (fl0 && n != 0));
            if (fv0 && bus.frm_ready) m_fv = 1'b0;
            if (send) begin
                m_fd = {4'(n), pack(m_q)};
                m_fv = 1'b1;
                m_q.delete();
            end
            m_flush = (send || n == 0) ? 1'b0 : fl0;
            if (flush_req || (ph0 == 0 && test_ending)) m_flush = 1'b1;
            m_drop = 1'b0;
            if (ph0 == 0 && bus.atom_valid) begin
                if (m_q.size() < 15) m_q.push_back(bus.atom);
                else m_drop = 1'b1;
            end
`ifdef DCT_DROP_COUNT_EN
            if (drop0 && m_dcnt < 255) m_dcnt++;
`endif
            if (ph0 == 0 && test_ending) m_phase = 1;
            else if (ph0 == 1 && n == 0 && !fv0) m_phase = 2;
            m_ended = (m_phase == 2);
        end
    end

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        cmp("dct_buffer", 64'(dct_buffer), 64'(pack(m_q)));
        cmp("dct_count", 64'(dct_count), 64'(m_q.size()));
        cmp("frm_valid", 64'(bus.frm_valid), 64'(m_fv));
        cmp("frm_data", 64'(bus.frm_data), 64'(m_fd));
        cmp("atom_drop", 64'(atom_drop), 64'(m_drop));
        cmp("drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
        cmp("test_has_ended", 64'(test_has_ended), 64'(m_ended));
        if (atom_drop === 1'b1) seen_drops++;
    end

    task automatic cyc(input logic av, input logic [1:0] a);
        bus.atom_valid = av;
        bus.atom = a;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input int maxc, output logic [33:0] d);
        d = 34'd0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.frm_valid === 1'b1) begin
                d = bus.frm_data;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL frame_timeout actual=no_frame expected=frame at %0t", $time);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] fr;
        int d0;
        bit got;
        bus.atom_valid = 1'b0;
        bus.atom = 2'd0;
        bus.frm_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        cmp("rst_count", 64'(dct_count), 64'd0);
        cmp("rst_buffer", 64'(dct_buffer), 64'd0);
        cmp("rst_frm_valid", 64'(bus.frm_valid), 64'd0);
        cmp("rst_frm_data", 64'(bus.frm_data), 64'd0);
        cmp("rst_ended", 64'(test_has_ended), 64'd0);
        cmp("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Full buffer of atoms i mod 4.
        for (int i = 0; i < 15; i++) cyc(1'b1, 2'(i % 4));
        cyc(1'b0, 2'd0);
        wait_frame(5, fr);
        cmp("full_frame", 64'(fr), 64'({4'd15, 30'h24E4E4E4}));
        cmp("full_count_after", 64'(dct_count), 64'd0);

        // Partial flush, then a flush of an empty buffer.
        cyc(1'b1, 2'd3); cyc(1'b1, 2'd1); cyc(1'b1, 2'd2);
        bus.atom_valid = 1'b0;
        flush_req = 1'b1; cyc(1'b0, 2'd0); flush_req = 1'b0;
        wait_frame(5, fr);
        cmp("flush_frame", 64'(fr), 64'({4'd3, 30'h00000027}));
        repeat (3) cyc(1'b0, 2'd0);
        flush_req = 1'b1; cyc(1'b0, 2'd0); flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp("empty_flush_no_frame", 64'(bus.frm_valid), 64'd0);
        end

        // Back-pressure overflow.
        d0 = seen_drops;
        bus.frm_ready = 1'b0;
        for (int i = 0; i < 40; i++) cyc(1'b1, 2'($urandom_range(0, 3)));
        repeat (2) cyc(1'b0, 2'd0);
        cmp("overflow_drops", 64'(seen_drops - d0), 64'd10);
        cmp("overflow_count", 64'(dct_count), 64'd15);
`ifdef DCT_DROP_COUNT_EN
        cmp("overflow_drop_cnt", 64'(drop_cnt), 64'd10);
`else
        cmp("overflow_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        bus.frm_ready = 1'b1;
        repeat (10) cyc(1'b0, 2'd0);

        // Continuous stream: 16th atom rides the transfer cycle.
        d0 = seen_drops;
        for (int i = 0; i < 20; i++) cyc(1'b1, 2'($urandom_range(0, 3)));
        cmp("stream_count", 64'(dct_count), 64'd5);
        cyc(1'b0, 2'd0);
        cmp("stream_no_drop", 64'(seen_drops - d0), 64'd0);

        // Random traffic.
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 150; i++) begin
                flush_req = ($urandom_range(0, 19) == 0);
                bus.frm_ready = (seg % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                               : ($urandom_range(0, 3) == 0);
                cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
            end
        end
        flush_req = 1'b0;
        bus.frm_ready = 1'b1;
        flush_req = 1'b1; cyc(1'b0, 2'd0); flush_req = 1'b0;
        repeat (20) cyc(1'b0, 2'd0);

        // End-of-test with seven buffered atoms and a stalled consumer.
        bus.frm_ready = 1'b0;
        for (int i = 0; i < 7; i++) cyc(1'b1, 2'd1);
        test_ending = 1'b1; cyc(1'b0, 2'd0); test_ending = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'($urandom_range(0, 3)));
        wait_frame(3, fr);
        cmp("end_frame", 64'(fr), 64'({4'd7, 30'h00001555}));
        bus.frm_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = (test_has_ended === 1'b1);
        end
        cmp("test_has_ended_rise", 64'(got), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'd2);
            cmp("ended_sticky", 64'(test_has_ended), 64'd1);
            cmp("ended_ignores_atoms", 64'(dct_count), 64'd0);
        end

        // Asynchronous reset with a pending frame and a partial buffer.
        reset_n = 1'b0; cyc(1'b0, 2'd0); reset_n = 1'b1;
        bus.frm_ready = 1'b0;
        for (int i = 0; i < 24; i++) cyc(1'b1, 2'($urandom_range(0, 3)));
        cmp("pre_reset_count", 64'(dct_count), 64'd9);
        cmp("pre_reset_valid", 64'(bus.frm_valid), 64'd1);
        bus.atom_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        cmp("async_rst_outputs", 64'({dct_buffer, dct_count, bus.frm_valid, atom_drop, test_has_ended}), 64'd0);
        cmp("async_rst_frm_data", 64'(bus.frm_data), 64'd0);
        cmp("async_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.frm_ready = 1'b1;
        cyc(1'b1, 2'd3);
        cmp("resume_count", 64'(dct_count), 64'd1);
        cmp("resume_buffer", 64'(dct_buffer), 64'd3);
        repeat (3) cyc(1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
